// File: rtl/mem_loader.sv
// mem_loader: writer side of the Simplez program memory.
// Parses a framed byte stream (HDR, CNT_HI, CNT_LO, N x {D_HI, D_LO}, CHK) and
// writes 12-bit words to sequential addresses starting at 0.
module mem_loader #(
  parameter int unsigned AW  = 9,
  parameter int unsigned DW  = 12,
  parameter logic [7:0]  HDR = 8'h4C
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    StIdle,
    StCntHi,
    StCntLo,
    StDataHi,
    StDataLo,
    StCheck,
    StError
  } state_e;

  state_e          state_q, state_d;
  logic            cnt_hi_q, cnt_hi_d;
  logic [AW-1:0]   word_cnt_q, word_cnt_d;
  logic [AW-1:0]   addr_cnt_q, addr_cnt_d;
  logic [3:0]      nib_q, nib_d;
  logic [7:0]      chk_q, chk_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_data_q, mem_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // State and output registers; every output is registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cnt_hi_q   <= 1'b0;
      word_cnt_q <= '0;
      addr_cnt_q <= '0;
      nib_q      <= '0;
      chk_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_hi_q   <= cnt_hi_d;
      word_cnt_q <= word_cnt_d;
      addr_cnt_q <= addr_cnt_d;
      nib_q      <= nib_d;
      chk_q      <= chk_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Frame parser: advances only on a received byte.
  always_comb begin
    state_d    = state_q;
    cnt_hi_d   = cnt_hi_q;
    word_cnt_d = word_cnt_q;
    addr_cnt_d = addr_cnt_q;
    nib_d      = nib_q;
    chk_d      = chk_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;

    if (rx_valid) begin
      case (state_q)
        // ERROR recovers exactly like IDLE; err is cleared on the new header.
        StIdle, StError: begin
          if (rx_data == HDR) begin
            state_d    = StCntHi;
            busy_d     = 1'b1;
            err_d      = 1'b0;
            chk_d      = '0;
            addr_cnt_d = '0;
          end
        end
        StCntHi: begin
          if (|rx_data[7:1]) begin
            state_d = StError;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            cnt_hi_d = rx_data[0];
            state_d  = StCntLo;
          end
        end
        StCntLo: begin
          // Count field holds N-1, so a zero counter means one word remains.
          word_cnt_d = AW'({cnt_hi_q, rx_data});
          state_d    = StDataHi;
        end
        StDataHi: begin
          if (|rx_data[7:4]) begin
            state_d = StError;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            nib_d   = rx_data[3:0];
            chk_d   = chk_q ^ rx_data;
            state_d = StDataLo;
          end
        end
        StDataLo: begin
          chk_d      = chk_q ^ rx_data;
          mem_we_d   = 1'b1;
          mem_addr_d = addr_cnt_q;
          mem_data_d = DW'({nib_q, rx_data});
          addr_cnt_d = addr_cnt_q + AW'(1);
          if (word_cnt_q == '0) begin
            state_d = StCheck;
          end else begin
            word_cnt_d = word_cnt_q - AW'(1);
            state_d    = StDataHi;
          end
        end
        StCheck: begin
          if (rx_data == chk_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = StError;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: expected writes go into a scoreboard
// queue as stimulus is driven and are popped when the DUT strobes mem_we.
module tb_mem_loader;

  localparam int unsigned AW  = 9;
  localparam int unsigned DW  = 12;
  localparam logic [7:0]  HDR = 8'h4C;

  logic          clk;
  logic          rstn;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          busy;
  logic          done;
  logic          err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    words[$];

  mem_loader #(
    .AW (AW),
    .DW (DW),
    .HDR(HDR)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rstn && done) done_cnt++;
    if (rstn && mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write",
                 mem_addr, mem_data);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                   mem_addr, mem_data, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // Idle for gap cycles, then present one byte for one cycle.
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Send a frame carrying words[]; stop_after>0 truncates after that many words.
  task automatic send_frame(input int gap, input logic [7:0] chk_flip, input int stop_after);
    logic [8:0] cnt;
    logic [7:0] chk;
    logic [7:0] dh;
    logic [7:0] dl;
    logic [8:0] a;
    cnt = 9'(words.size() - 1);
    chk = 8'h00;
    send_byte(HDR, gap);
    send_byte({7'b0, cnt[8]}, gap);
    send_byte(cnt[7:0], gap);
    for (int i = 0; i < words.size(); i++) begin
      dh  = {4'h0, words[i][11:8]};
      dl  = words[i][7:0];
      chk = chk ^ dh ^ dl;
      a   = 9'(i);
      send_byte(dh, gap);
      exp_q.push_back({a, words[i]});
      send_byte(dl, gap);
      if (stop_after == i + 1) return;
    end
    send_byte(chk ^ chk_flip, gap);
  endtask

  task automatic load_three();
    words = {};
    words.push_back(12'h100);
    words.push_back(12'hE00);
    words.push_back(12'h555);
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending_writes: got %0d outstanding, expected 0", name, exp_q.size());
      exp_q = {};
    end
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_data, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h busy=%b done=%b err=%b, expected all 0",
               mem_we, mem_addr, mem_data, busy, done, err);
    end
    rstn = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_three_words(input string name, input int lead);
    int d0;
    load_three();
    if (lead != 0) begin
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      send_byte(8'h13, 0);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_lead_busy: got %b, expected 0", name, busy);
      end
    end
    d0 = done_cnt;
    send_frame(1, 8'h00, 0);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: got done=%b err=%b busy=%b, expected 1 0 0", name, done, err, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL %s_done_pulse: got done=%b pulses=%0d, expected 0 and 1", name, done,
               done_cnt - d0);
    end
    checks++;
    if (mem_addr !== 9'h002 || mem_data !== 12'h555) begin
      errors++;
      $display("FAIL %s_hold: got addr=%h data=%h, expected 002 555", name, mem_addr, mem_data);
    end
    check_sb_empty(name);
  endtask

  task automatic test_bad_checksum();
    int d0;
    load_three();
    d0 = done_cnt;
    send_frame(0, 8'h01, 0);
    @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || done_cnt != d0) begin
      errors++;
      $display("FAIL bad_chk: got err=%b busy=%b done_pulses=%0d, expected 1 0 0", err, busy,
               done_cnt - d0);
    end
    check_sb_empty("bad_chk");
    // A following good frame clears err and completes.
    send_byte(HDR, 0);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bad_chk_restart: got err=%b busy=%b, expected 0 1", err, busy);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    exp_q.push_back({9'h000, 12'h0AB});
    send_byte(8'hAB, 0);
    send_byte(8'hAB, 0);
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL bad_chk_recover: got done=%b err=%b, expected 1 0", done, err);
    end
    check_sb_empty("bad_chk_recover");
  endtask

  task automatic test_format_errors();
    // D_HI with a nonzero upper nibble: no write, immediate error.
    send_byte(HDR, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h1E, 0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dhi_err: got err=%b busy=%b, expected 1 0", err, busy);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(posedge clk);
    check_sb_empty("dhi_err");
    // CNT_HI with bits above bit0 set.
    send_byte(HDR, 0);
    send_byte(8'h02, 0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cnthi_err: got err=%b busy=%b, expected 1 0", err, busy);
    end
  endtask

  task automatic test_full_512(input string name, input int gap);
    int d0;
    words = {};
    for (int k = 0; k < 512; k++) words.push_back(12'(k));
    d0 = done_cnt;
    send_frame(gap, 8'h00, 0);
    checks++;
    if (done !== 1'b1 || mem_addr !== 9'h1FF || mem_data !== 12'h1FF) begin
      errors++;
      $display("FAIL %s_end: got done=%b addr=%h data=%h, expected 1 1ff 1ff", name, done,
               mem_addr, mem_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0 + 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: got pulses=%0d err=%b, expected 1 0", name, done_cnt - d0, err);
    end
    check_sb_empty(name);
  endtask

  task automatic test_reset_mid_frame();
    words = {};
    words.push_back(12'h123);
    words.push_back(12'h456);
    words.push_back(12'h789);
    words.push_back(12'hABC);
    send_frame(0, 8'h00, 2);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_data, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got we=%b addr=%h data=%h busy=%b done=%b err=%b, expected all 0",
               mem_we, mem_addr, mem_data, busy, done, err);
    end
    check_sb_empty("midrst");
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_quiet: got we=%b busy=%b, expected 0 0", mem_we, busy);
    end
    test_three_words("midrst_reload", 0);
  endtask

  initial begin
    test_reset();
    test_three_words("three", 0);
    test_bad_checksum();
    test_three_words("lead", 1);
    test_format_errors();
    test_full_512("full_gap", 1);
    test_full_512("full_b2b", 0);
    test_reset_mid_frame();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
